// File: rtl/register_file_wb.sv
// Write-back side register file: two combinational read ports, one write port,
// and a per-register pending-write scoreboard. Optional macro REGFILE_BYPASS_EN.
module register_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueReg,
  output logic                  busy1,
  output logic                  busy2,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regVec;
  logic [NUM_REGS-1:0]                 pendingVec;

  logic setHit;
  logic clrHit;
  logic setEff;
  logic clrEff;

  assign setHit = issueValid && (issueReg != '0);
  assign clrHit = RegWrite && (writeReg != '0);

  // Register 0 is hard-wired: no storage, never pending.
  assign regVec[0]     = '0;
  assign pendingVec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] valueReg;
      logic                  pendReg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valueReg <= RESET_VALUE;
        end else if (clrHit && (writeReg == ADDR_WIDTH'(gi))) begin
          valueReg <= writeData;
        end
      end

      // Set is checked first so a newer producer wins over a same-cycle completion.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pendReg <= 1'b0;
        end else if (setHit && (issueReg == ADDR_WIDTH'(gi))) begin
          pendReg <= 1'b1;
        end else if (clrHit && (writeReg == ADDR_WIDTH'(gi))) begin
          pendReg <= 1'b0;
        end
      end

      assign regVec[gi]     = valueReg;
      assign pendingVec[gi] = pendReg;
    end
  endgenerate

  // Count only transitions that actually flip a bit, keeping it equal to popcount.
  assign setEff = setHit && !pendingVec[issueReg];
  assign clrEff = clrHit && pendingVec[writeReg] && !(setHit && (issueReg == writeReg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendingCount <= '0;
    end else if (setEff && !clrEff) begin
      pendingCount <= pendingCount + 1'b1;
    end else if (clrEff && !setEff) begin
      pendingCount <= pendingCount - 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = clrHit && (writeReg == readReg1);
  assign byp2 = clrHit && (writeReg == readReg2);

  assign readData1 = byp1 ? writeData : regVec[readReg1];
  assign readData2 = byp2 ? writeData : regVec[readReg2];

  // A completing producer frees the register now unless another issue re-claims it.
  assign busy1 = pendingVec[readReg1] && !(byp1 && !(setHit && (issueReg == readReg1)));
  assign busy2 = pendingVec[readReg2] && !(byp2 && !(setHit && (issueReg == readReg2)));
`else
  assign readData1 = regVec[readReg1];
  assign readData2 = regVec[readReg2];
  assign busy1     = pendingVec[readReg1];
  assign busy2     = pendingVec[readReg2];
`endif

endmodule

// File: tb/tb_register_file_wb.sv
// Directed self-checking bench for register_file_wb; bypass expectations follow REGFILE_BYPASS_EN.
module tb_register_file_wb;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        issueValid;
  logic [4:0]  issueReg;
  logic        busy1;
  logic        busy2;
  logic [5:0]  pendingCount;

  int testsRun = 0;
  int testsFailed = 0;

  register_file_wb dut (
    .clk(clk),
    .rst(rst),
    .RegWrite(RegWrite),
    .writeReg(writeReg),
    .writeData(writeData),
    .readReg1(readReg1),
    .readReg2(readReg2),
    .readData1(readData1),
    .readData2(readData2),
    .issueValid(issueValid),
    .issueReg(issueReg),
    .busy1(busy1),
    .busy2(busy2),
    .pendingCount(pendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; writeReg = '0; writeData = '0;
    issueValid = 1'b0; issueReg = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    testsRun++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      testsFailed++;
      $display("FAIL reset_data: got %h/%h want 0/0", readData1, readData2);
    end
    testsRun++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || pendingCount !== 6'd0) begin
      testsFailed++;
      $display("FAIL reset_sb: busy %b%b count %0d want 00 0", busy1, busy2, pendingCount);
    end
    $display("[TB] reset: data=%h/%h busy=%b%b count=%0d", readData1, readData2, busy1, busy2, pendingCount);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    RegWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
    tick();
    idle();
    readReg1 = 5'd5;
    #1;
    testsRun++;
    if (readData1 !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("FAIL write_r5: got %h want deadbeef", readData1);
    end
    $display("[TB] write r5: readData1=%h", readData1);
    RegWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
    tick();
    idle();
    readReg2 = 5'd0;
    #1;
    testsRun++;
    if (readData2 !== 32'h0) begin
      testsFailed++;
      $display("FAIL write_r0: got %h want 0", readData2);
    end
    $display("[TB] write r0: readData2=%h", readData2);
  endtask

  task automatic test_scoreboard();
    issueValid = 1'b1; issueReg = 5'd8;
    tick();
    issueReg = 5'd9;
    tick();
    idle();
    readReg1 = 5'd8;
    #1;
    testsRun++;
    if (pendingCount !== 6'd2 || busy1 !== 1'b1) begin
      testsFailed++;
      $display("FAIL sb_issue: count %0d busy1 %b want 2 1", pendingCount, busy1);
    end
    $display("[TB] issue 8,9: count=%0d busy1=%b", pendingCount, busy1);
    RegWrite = 1'b1; writeReg = 5'd8; writeData = 32'h88;
    tick();
    idle();
    #1;
    testsRun++;
    if (pendingCount !== 6'd1 || busy1 !== 1'b0) begin
      testsFailed++;
      $display("FAIL sb_clear: count %0d busy1 %b want 1 0", pendingCount, busy1);
    end
    $display("[TB] writeback 8: count=%0d busy1=%b", pendingCount, busy1);
    issueValid = 1'b1; issueReg = 5'd8;
    tick();
    issueReg = 5'd0;
    tick();
    RegWrite = 1'b1; writeReg = 5'd20; writeData = 32'h20;
    tick();
    idle();
    #1;
    testsRun++;
    if (pendingCount !== 6'd2 || busy1 !== 1'b1) begin
      testsFailed++;
      $display("FAIL sb_reissue: count %0d busy1 %b want 2 1", pendingCount, busy1);
    end
    $display("[TB] reissue 8, issue 0, clear idle 20: count=%0d busy1=%b", pendingCount, busy1);
  endtask

  task automatic test_simultaneous();
    issueValid = 1'b1; issueReg = 5'd3;
    tick();
    issueReg = 5'd8;
    tick();
    issueReg = 5'd3; RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'h33;
    tick();
    idle();
    readReg1 = 5'd3;
    #1;
    testsRun++;
    if (pendingCount !== 6'd3 || busy1 !== 1'b1) begin
      testsFailed++;
      $display("FAIL sim_same: count %0d busy1 %b want 3 1", pendingCount, busy1);
    end
    $display("[TB] set+clear r3: count=%0d busy1=%b", pendingCount, busy1);
    issueValid = 1'b1; issueReg = 5'd4; RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'h34;
    tick();
    idle();
    readReg1 = 5'd4; readReg2 = 5'd3;
    #1;
    testsRun++;
    if (pendingCount !== 6'd3 || busy1 !== 1'b1 || busy2 !== 1'b0) begin
      testsFailed++;
      $display("FAIL sim_diff: count %0d busy %b%b want 3 10", pendingCount, busy1, busy2);
    end
    $display("[TB] set r4 clear r3: count=%0d busy=%b%b", pendingCount, busy1, busy2);
    // Pending now {4,8,9}; a same-cycle set of a new index plus clear of a pending one nets zero.
    issueValid = 1'b1; issueReg = 5'd12; RegWrite = 1'b1; writeReg = 5'd9; writeData = 32'h99;
    tick();
    idle();
    readReg1 = 5'd12; readReg2 = 5'd9;
    #1;
    testsRun++;
    if (pendingCount !== 6'd3 || busy1 !== 1'b1 || busy2 !== 1'b0 || readData2 !== 32'h99) begin
      testsFailed++;
      $display("FAIL sim_net0: count %0d busy %b%b data %h want 3 10 99", pendingCount, busy1, busy2, readData2);
    end
    $display("[TB] set r12 clear r9: count=%0d busy=%b%b data=%h", pendingCount, busy1, busy2, readData2);
  endtask

  task automatic test_bypass();
    logic [31:0] expBefore;
    logic        expBusy;
`ifdef REGFILE_BYPASS_EN
    expBefore = 32'hA5A5A5A5;
    expBusy   = 1'b0;
`else
    expBefore = 32'h0;
    expBusy   = 1'b1;
`endif
    readReg1 = 5'd7; RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'hA5A5A5A5;
    #1;
    testsRun++;
    if (readData1 !== expBefore) begin
      testsFailed++;
      $display("FAIL bypass_before: got %h want %h", readData1, expBefore);
    end
    $display("[TB] same-cycle r7 read: readData1=%h", readData1);
    tick();
    idle();
    #1;
    testsRun++;
    if (readData1 !== 32'hA5A5A5A5) begin
      testsFailed++;
      $display("FAIL bypass_after: got %h want a5a5a5a5", readData1);
    end
    $display("[TB] after edge r7: readData1=%h", readData1);
    issueValid = 1'b1; issueReg = 5'd11;
    tick();
    idle();
    readReg1 = 5'd11; RegWrite = 1'b1; writeReg = 5'd11; writeData = 32'hB;
    #1;
    testsRun++;
    if (busy1 !== expBusy) begin
      testsFailed++;
      $display("FAIL bypass_busy: got %b want %b", busy1, expBusy);
    end
    $display("[TB] completing r11 busy1=%b", busy1);
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    RegWrite = 1'b1; writeReg = 5'd10; writeData = 32'h55;
    tick();
    idle();
    readReg1 = 5'd10; readReg2 = 5'd4;
    #1;
    testsRun++;
    if (pendingCount !== 6'd3 || readData1 !== 32'h55) begin
      testsFailed++;
      $display("FAIL pre_reset: count %0d r10 %h want 3 55", pendingCount, readData1);
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if (pendingCount !== 6'd0 || readData1 !== 32'h0 || busy2 !== 1'b0) begin
      testsFailed++;
      $display("FAIL mid_reset: count %0d r10 %h busy2 %b want 0 0 0", pendingCount, readData1, busy2);
    end
    $display("[TB] mid reset: count=%0d r10=%h busy2=%b", pendingCount, readData1, busy2);
    rst = 1'b0;
    RegWrite = 1'b1; writeReg = 5'd10; writeData = 32'h77;
    tick();
    idle();
    #1;
    testsRun++;
    if (readData1 !== 32'h77) begin
      testsFailed++;
      $display("FAIL post_reset_write: got %h want 77", readData1);
    end
    $display("[TB] post-reset write r10: readData1=%h", readData1);
  endtask

  initial begin
    rst = 1'b0;
    readReg1 = '0; readReg2 = '0;
    idle();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
- Architectural register file on the write-back side of the MIPS pipeline.
- Accepts the write-back stage's MemtoReg-selected writeData, writeReg and RegWrite.
- Serves two combinational read ports to decode.
- Holds a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight producers.

Parameters:
DATA_WIDTH, 32, width of each register and of data ports
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH (32)
RESET_VALUE, 0, value loaded into every register on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
RegWrite  input  1  write-back write enable
writeReg  input  ADDR_WIDTH  write-back destination index
writeData  input  DATA_WIDTH  write-back data (output of write_back)
readReg1  input  ADDR_WIDTH  read port 1 index
readReg2  input  ADDR_WIDTH  read port 2 index
readData1  output  DATA_WIDTH  read port 1 data
readData2  output  DATA_WIDTH  read port 2 data
issueValid  input  1  decode issues an instruction that will write issueReg
issueReg  input  ADDR_WIDTH  destination of issued instruction
busy1  output  1  readReg1 has a pending (unwritten) producer
busy2  output  1  readReg2 has a pending producer
pendingCount  output  ADDR_WIDTH+1  number of registers with pending bit set

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All registers = RESET_VALUE.
  - All pending bits = 0.
  - pendingCount = 0.
  - busy1/busy2 = 0.
  - Register 0 is always 0 regardless of RESET_VALUE.
- Write:
  - On posedge clk, if RegWrite && writeReg != 0: reg[writeReg] <= writeData.
  - Writes to index 0 are discarded.
  - Write latency 1 cycle.
- Read:
  - readDataN = reg[readRegN], purely combinational.
  - readRegN == 0 always returns 0.
- Scoreboard set:
  - On posedge, if issueValid && issueReg != 0: pending[issueReg] <= 1.
- Scoreboard clear:
  - On posedge, if RegWrite && writeReg != 0: pending[writeReg] <= 0.
- Simultaneous set and clear of same index in one cycle: set wins (newer producer outstanding); bit ends at 1.
- Set of an already-pending register: bit stays 1, count unchanged.
- Clear of a non-pending register: no change, count unchanged.
- pendingCount:
  - Registered; always equals popcount(pending) after each edge.
  - Updated by +1, -1 or 0 per cycle as bits actually change.
  - Set and clear on different indices in the same cycle give net 0.
  - Must never underflow or exceed NUM_REGS-1.
- busyN = pending[readRegN]. Index 0 is never busy.
- Reset asserted mid-operation: registers, pending and count are cleared immediately, without waiting for clk. Writes/issues in that cycle are lost.
- Reset deassertion: first edge with rst low behaves normally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: internal write-to-read bypass for same-cycle write-back and read.
  - If RegWrite && writeReg != 0 && writeReg == readRegN: readDataN = writeData in the same cycle.
  - busyN is forced 0 in that case (producer completes this cycle), unless issueValid sets the same index that cycle.
  - This supplies the MIPS "write first half, read second half" semantics.
- Undefined: no bypass.
  - Reads return the pre-edge register value.
  - busyN reflects the pending bit only; decode must stall one extra cycle.

Test Plan:
- Reset check: assert rst with no clock edge -> readData1/2 = 0, busy1/2 = 0, pendingCount = 0 immediately.
- Write/read: RegWrite=1, writeReg=5, writeData=32'hDEADBEEF, one edge, then readReg1=5 -> readData1 = 32'hDEADBEEF. Repeat with writeReg=0, writeData=32'h1234 -> readReg2=0 gives 0.
- Scoreboard: issue reg 8, then reg 9 -> pendingCount=2, busy1=1 for readReg1=8. Write-back reg 8 -> pendingCount=1, busy1=0. Issue reg 8 again -> pendingCount=2.
- Simultaneous set/clear:
  - pending[3]=1; same cycle issueReg=3 and writeReg=3 -> pending[3] stays 1, count unchanged.
  - issueReg=4 with writeReg=3 -> count unchanged, busy on 4 = 1, busy on 3 = 0.
- Bypass: readReg1=7, RegWrite=1, writeReg=7, writeData=32'hA5A5A5A5 in the same cycle, reg7 previously 0.
  - With REGFILE_BYPASS_EN: readData1 = 32'hA5A5A5A5 before the edge.
  - Without it: readData1 = 0 before the edge, 32'hA5A5A5A5 after.
- Reset mid-operation: with pendingCount=3 and reg 10 = 32'h55, pulse rst between edges -> count=0, reg 10 reads 0, subsequent write to reg 10 works on the next edge.
